// File: rtl/tape_arbiter_if.sv
// tape_arbiter_if: requester handshakes plus the single RAM port of the tape arbiter.
interface tape_arbiter_if #(parameter int ADDR_W = 12);
  logic              cpu_req, dbg_req, vga_req;
  logic              cpu_we, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr, vga_addr;
  logic [7:0]        cpu_wdata, dbg_wdata;
  logic              cpu_gnt, dbg_gnt, vga_gnt;
  logic              cpu_rvalid, dbg_rvalid, vga_rvalid;
  logic [7:0]        rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, dbg_req, vga_req, cpu_we, dbg_we, cpu_addr, dbg_addr, vga_addr,
           cpu_wdata, dbg_wdata, mem_rdata,
    output cpu_gnt, dbg_gnt, vga_gnt, cpu_rvalid, dbg_rvalid, vga_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, dbg_req, vga_req, cpu_we, dbg_we, cpu_addr, dbg_addr, vga_addr,
           cpu_wdata, dbg_wdata, mem_rdata,
    input  cpu_gnt, dbg_gnt, vga_gnt, cpu_rvalid, dbg_rvalid, vga_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tape_arbiter.sv
// tape_arbiter: CPU-priority arbiter for the tape RAM with starvation escape and dbg/vga round robin.
module tape_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           resetn,
  tape_arbiter_if.slave bus
);
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
  logic [7:0]        dbg_wait_q, dbg_wait_d, vga_wait_q, vga_wait_d;
  logic              rr_q, rr_d, run_q;
  logic              cpu_rvalid_q, dbg_rvalid_q, vga_rvalid_q;
  logic              cpu_rvalid_d, dbg_rvalid_d, vga_rvalid_d;
  logic              go, dbg_st, vga_st, cpu_gnt, dbg_gnt, vga_gnt;
  logic [ADDR_W-1:0] mem_addr;
  always_comb begin
    // run_q holds grants off until the first edge after reset release
    go           = resetn & run_q;
    dbg_st       = bus.dbg_req & (dbg_wait_q == LIM);
    vga_st       = bus.vga_req & (vga_wait_q == LIM);
    dbg_gnt      = go & (dbg_st ? (!vga_st | !rr_q)
                                : (!vga_st & !bus.cpu_req & bus.dbg_req & (!bus.vga_req | !rr_q)));
    vga_gnt      = go & (vga_st ? (!dbg_st | rr_q)
                                : (!dbg_st & !bus.cpu_req & bus.vga_req & (!bus.dbg_req | rr_q)));
    cpu_gnt      = go & bus.cpu_req & !dbg_st & !vga_st;
    dbg_wait_d   = (!bus.dbg_req | dbg_gnt) ? 8'd0 : (dbg_wait_q == LIM) ? LIM : dbg_wait_q + 8'd1;
    vga_wait_d   = (!bus.vga_req | vga_gnt) ? 8'd0 : (vga_wait_q == LIM) ? LIM : vga_wait_q + 8'd1;
    rr_d         = dbg_gnt ? 1'b1 : vga_gnt ? 1'b0 : rr_q;
    cpu_rvalid_d = cpu_gnt & !bus.cpu_we;
    dbg_rvalid_d = dbg_gnt & !bus.dbg_we;
    vga_rvalid_d = vga_gnt;
    mem_addr     = dbg_gnt ? bus.dbg_addr : vga_gnt ? bus.vga_addr : bus.cpu_addr;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      dbg_wait_q   <= 8'd0;
      vga_wait_q   <= 8'd0;
      rr_q         <= 1'b0;
      run_q        <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      vga_rvalid_q <= 1'b0;
    end else begin
      dbg_wait_q   <= dbg_wait_d;
      vga_wait_q   <= vga_wait_d;
      rr_q         <= rr_d;
      run_q        <= 1'b1;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      vga_rvalid_q <= vga_rvalid_d;
    end
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.rdata      = bus.mem_rdata;
  assign bus.mem_en     = cpu_gnt | dbg_gnt | vga_gnt;
  assign bus.mem_we     = cpu_gnt ? bus.cpu_we : dbg_gnt & bus.dbg_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;
endmodule

// File: tb/tb_tape_arbiter.sv
// tb_tape_arbiter: vector table, directed corner sequences and a random run against a rule-level model.
module tb_tape_arbiter;
  logic clk = 1'b0, resetn = 1'b1;
  always #5 clk = ~clk;

  tape_arbiter_if #(.ADDR_W(12)) bus0 ();
  tape_arbiter_if #(.ADDR_W(12)) bus1 ();
  tape_arbiter #(.ADDR_W(12), .STARVE_LIMIT(8)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  tape_arbiter #(.ADDR_W(12), .STARVE_LIMIT(2)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  // index 0 = cpu, 1 = dbg, 2 = vga
  logic [2:0]  req [2];
  logic [1:0]  we  [2];
  logic [11:0] ad  [2][3];
  logic [7:0]  wd  [2][2];
  logic [2:0]  gnt [2], rv [2];
  logic [7:0]  rd  [2], mwd [2];
  logic        men [2], mwe [2];
  logic [11:0] madr[2];

  assign bus0.cpu_req = req[0][0]; assign bus0.dbg_req = req[0][1]; assign bus0.vga_req = req[0][2];
  assign bus0.cpu_we = we[0][0]; assign bus0.dbg_we = we[0][1];
  assign bus0.cpu_addr = ad[0][0]; assign bus0.dbg_addr = ad[0][1]; assign bus0.vga_addr = ad[0][2];
  assign bus0.cpu_wdata = wd[0][0]; assign bus0.dbg_wdata = wd[0][1];
  assign bus1.cpu_req = req[1][0]; assign bus1.dbg_req = req[1][1]; assign bus1.vga_req = req[1][2];
  assign bus1.cpu_we = we[1][0]; assign bus1.dbg_we = we[1][1];
  assign bus1.cpu_addr = ad[1][0]; assign bus1.dbg_addr = ad[1][1]; assign bus1.vga_addr = ad[1][2];
  assign bus1.cpu_wdata = wd[1][0]; assign bus1.dbg_wdata = wd[1][1];
  assign gnt[0] = {bus0.vga_gnt, bus0.dbg_gnt, bus0.cpu_gnt};
  assign gnt[1] = {bus1.vga_gnt, bus1.dbg_gnt, bus1.cpu_gnt};
  assign rv[0] = {bus0.vga_rvalid, bus0.dbg_rvalid, bus0.cpu_rvalid};
  assign rv[1] = {bus1.vga_rvalid, bus1.dbg_rvalid, bus1.cpu_rvalid};
  assign rd[0] = bus0.rdata; assign rd[1] = bus1.rdata;
  assign men[0] = bus0.mem_en; assign men[1] = bus1.mem_en;
  assign mwe[0] = bus0.mem_we; assign mwe[1] = bus1.mem_we;
  assign madr[0] = bus0.mem_addr; assign madr[1] = bus1.mem_addr;
  assign mwd[0] = bus0.mem_wdata; assign mwd[1] = bus1.mem_wdata;

  // synchronous-read tape RAMs behind each arbiter
  logic [7:0] ram0 [4096], ram1 [4096];
  always @(posedge clk) begin
    if (bus0.mem_en) begin
      if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wdata;
      else bus0.mem_rdata <= ram0[bus0.mem_addr];
    end
    if (bus1.mem_en) begin
      if (bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
      else bus1.mem_rdata <= ram1[bus1.mem_addr];
    end
  end

  int errors = 0, checks = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      req[d] = 3'b000; we[d] = 2'b00; wd[d][0] = 8'h00; wd[d][1] = 8'h00;
      for (int p = 0; p < 3; p++) ad[d][p] = 12'h000;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) req[d] = 3'b111;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_gnt%0d", d), gnt[d], 0);
      chk($sformatf("rst_mem_en%0d", d), men[d], 0);
      chk($sformatf("rst_rvalid%0d", d), rv[d], 0);
    end
    chk("rst_waits0", {dut0.dbg_wait_q, dut0.vga_wait_q, 7'd0, dut0.rr_q}, 0);
    chk("rst_waits1", {dut1.dbg_wait_q, dut1.vga_wait_q, 7'd0, dut1.rr_q}, 0);
    idle();
    @(posedge clk); #2 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // reference model: waits, round robin, pending read results and memory image per arbiter
  int         lim [2] = '{8, 2};
  int         mw  [2][2];
  int         mrr [2];
  logic [2:0] mrv [2];
  logic [7:0] mrd [2];
  logic [7:0] mmem[2][4096];

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      mw[d][0] = 0; mw[d][1] = 0; mrr[d] = 0; mrv[d] = 3'b000;
    end
  endtask

  function automatic int pick(int d);
    bit sd = req[d][1] && mw[d][0] == lim[d];
    bit sv = req[d][2] && mw[d][1] == lim[d];
    if (sd && sv) return mrr[d] ? 2 : 1;
    if (sd) return 1;
    if (sv) return 2;
    if (req[d][0]) return 0;
    if (req[d][1] && req[d][2]) return mrr[d] ? 2 : 1;
    if (req[d][1]) return 1;
    if (req[d][2]) return 2;
    return -1;
  endfunction

  function automatic bit pwe(int d, int w);
    return w == 2 ? 1'b0 : we[d][w];
  endfunction

  task automatic mcheck(int d, int w);
    chk($sformatf("rnd_gnt%0d", d), gnt[d], w < 0 ? 0 : 1 << w);
    chk($sformatf("rnd_onehot%0d", d), $countones(gnt[d]) <= 1, 1);
    chk($sformatf("rnd_rvalid%0d", d), rv[d], mrv[d]);
    if (mrv[d] != 0) chk($sformatf("rnd_rdata%0d", d), rd[d], mrd[d]);
    chk($sformatf("rnd_mem_en%0d", d), men[d], w >= 0);
    if (w >= 0) begin
      chk($sformatf("rnd_mem_we%0d", d), mwe[d], pwe(d, w));
      chk($sformatf("rnd_mem_addr%0d", d), madr[d], ad[d][w]);
      if (pwe(d, w)) chk($sformatf("rnd_mem_wdata%0d", d), mwd[d], wd[d][w]);
    end
  endtask

  task automatic mstep(int d, int w);
    for (int p = 1; p < 3; p++)
      mw[d][p-1] = (!req[d][p] || w == p) ? 0 : (mw[d][p-1] < lim[d] ? mw[d][p-1] + 1 : lim[d]);
    if (w == 1) mrr[d] = 1;
    else if (w == 2) mrr[d] = 0;
    mrv[d] = 3'b000;
    if (w >= 0) begin
      if (pwe(d, w)) mmem[d][ad[d][w]] = wd[d][w];
      else begin
        mrv[d][w] = 1'b1;
        mrd[d] = mmem[d][ad[d][w]];
      end
    end
  endtask

  // requesters hold an ungranted access; others may start a fresh one
  task automatic gen(int d, int w, int i);
    if (i < 16) begin
      req[d] = 3'b001; we[d][0] = 1'b1; ad[d][0] = 12'h100 + 12'(i); wd[d][0] = 8'(i * 7 + 3);
    end else
      for (int p = 0; p < 3; p++)
        if (!(req[d][p] && w != p)) begin
          req[d][p] = $urandom_range(0, 99) < (p == 0 ? (i < 1000 ? 85 : 30) : 45);
          ad[d][p] = 12'h100 + 12'($urandom_range(0, 15));
          if (p < 2) begin
            we[d][p] = 1'($urandom_range(0, 1));
            wd[d][p] = 8'($urandom);
          end
        end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [1:0]  we;
    logic [11:0] a0, a1, a2;
    logic [7:0]  w0, w1;
    logic [2:0]  eg, erv;
    logic [7:0]  erd;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w[2];
    int seq_c[10] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2};
    tbl[0]  = '{3'b001, 2'b01, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00};
    tbl[1]  = '{3'b001, 2'b01, 12'h010, 12'h000, 12'h000, 8'h5A, 8'h00, 3'b001, 3'b000, 8'h00};
    tbl[2]  = '{3'b001, 2'b00, 12'h010, 12'h000, 12'h000, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00};
    tbl[3]  = '{3'b000, 2'b00, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 3'b000, 3'b001, 8'h5A};
    tbl[4]  = '{3'b010, 2'b10, 12'h000, 12'h3FF, 12'h000, 8'h00, 8'hA5, 3'b010, 3'b000, 8'h00};
    tbl[5]  = '{3'b100, 2'b00, 12'h000, 12'h000, 12'h3FF, 8'h00, 8'h00, 3'b100, 3'b000, 8'h00};
    tbl[6]  = '{3'b000, 2'b00, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 3'b000, 3'b100, 8'hA5};
    tbl[7]  = '{3'b010, 2'b10, 12'h000, 12'hFFF, 12'h000, 8'h00, 8'h11, 3'b010, 3'b000, 8'h00};
    tbl[8]  = '{3'b100, 2'b00, 12'h000, 12'h000, 12'h3FF, 8'h00, 8'h00, 3'b100, 3'b000, 8'h00};
    tbl[9]  = '{3'b001, 2'b00, 12'hFFF, 12'h000, 12'h000, 8'h00, 8'h00, 3'b001, 3'b100, 8'hA5};
    tbl[10] = '{3'b001, 2'b00, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 3'b001, 3'b001, 8'h11};
    tbl[11] = '{3'b000, 2'b00, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 3'b000, 3'b001, 8'h00};
    tbl[12] = '{3'b110, 2'b00, 12'h000, 12'h000, 12'hFFF, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00};
    tbl[13] = '{3'b100, 2'b00, 12'h000, 12'h000, 12'hFFF, 8'h00, 8'h00, 3'b100, 3'b010, 8'h00};
    tbl[14] = '{3'b000, 2'b00, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 3'b000, 3'b100, 8'h11};
    idle();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      req[0] = tbl[i].req; we[0] = tbl[i].we;
      ad[0][0] = tbl[i].a0; ad[0][1] = tbl[i].a1; ad[0][2] = tbl[i].a2;
      wd[0][0] = tbl[i].w0; wd[0][1] = tbl[i].w1;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), gnt[0], tbl[i].eg);
      chk($sformatf("tbl%0d_rvalid", i), rv[0], tbl[i].erv);
      if (tbl[i].erv != 0) chk($sformatf("tbl%0d_rdata", i), rd[0], tbl[i].erd);
      @(posedge clk); #1;
    end

    // continuous CPU traffic: VGA forced through after STARVE_LIMIT lost cycles
    idle();
    for (int c = 0; c < 11; c++) begin
      req[0] = {c <= 8, 1'b0, 1'b1}; ad[0][0] = 12'h020; ad[0][2] = 12'h3FF;
      @(negedge clk);
      chk($sformatf("starve_cpu_gnt_c%0d", c), gnt[0][0], c != 8);
      chk($sformatf("starve_vga_gnt_c%0d", c), gnt[0][2], c == 8);
      chk($sformatf("starve_vga_rvalid_c%0d", c), rv[0][2], c == 9);
      if (c == 9) chk("starve_vga_rdata", rd[0], 8'hA5);
      @(posedge clk); #1;
    end

    // dut0: dbg/vga alternate from reset; dut1 (limit 2): all three contend
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req[0] = 3'b110; req[1] = 3'b111; ad[0][1] = 12'h3FF; ad[0][2] = 12'h3FF;
      @(negedge clk);
      chk($sformatf("rr_alt_c%0d", c), gnt[0], (c % 2 == 0) ? 3'b010 : 3'b100);
      chk($sformatf("all3_c%0d", c), gnt[1], 1 << seq_c[c]);
      if (c == 2) chk("all3_both_sat", {dut1.dbg_wait_q, dut1.vga_wait_q}, 16'h0202);
      if (c == 3) chk("all3_vga_sat", dut1.vga_wait_q, 8'd2);
      @(posedge clk); #1;
    end

    // async reset while a VGA read is being granted
    idle();
    req[0] = 3'b100; ad[0][2] = 12'h3FF;
    #1 chk("rstmid_vga_gnt", gnt[0], 3'b100);
    #1 resetn = 1'b0;
    req[0] = 3'b111;
    @(negedge clk);
    chk("rstmid_rvalid", rv[0], 3'b000);
    chk("rstmid_gnt", {men[0], gnt[0]}, 4'b0000);
    chk("rstmid_waits", {dut0.dbg_wait_q, dut0.vga_wait_q}, 16'h0000);
    @(posedge clk); #1;
    chk("rstmid_rvalid_after_edge", rv[0], 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("rstrel_no_gnt_before_edge", gnt[0], 3'b000);
    @(posedge clk); #1;
    chk("rstrel_first_gnt_cpu", gnt[0], 3'b001);

    // random traffic on both arbiters against the model
    do_reset();
    mreset();
    for (int d = 0; d < 2; d++) gen(d, -1, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        w[d] = pick(d);
        mcheck(d, w[d]);
        mstep(d, w[d]);
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) gen(d, w[d], i + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
